// File: rtl/decstage_if.sv
// ============================================================================
// decstage_if: fetch, write-back and execute-side signals of the decode stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface decstage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       instr_i;
  logic              instr_valid_i;
  logic              id_ready_o;
  logic              use_a_i;
  logic              use_b_i;
  logic              rf_b_sel_i;
  logic [1:0]        imm_mode_i;
  logic              sb_i;
  logic              is_load_i;
  logic              flush_i;
  logic              wb_en_i;
  logic              wb_lb_i;
  logic [REG_AW-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              ex_ready_i;
  logic              ex_valid_o;
  logic [DATA_W-1:0] ex_rf_a_o;
  logic [DATA_W-1:0] ex_rf_b_o;
  logic [DATA_W-1:0] ex_immed_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic              ex_load_o;
  logic              stall_o;

  modport slave (
    input  instr_i, instr_valid_i, use_a_i, use_b_i, rf_b_sel_i, imm_mode_i,
           sb_i, is_load_i, flush_i, wb_en_i, wb_lb_i, wb_addr_i, wb_data_i,
           ex_ready_i,
    output id_ready_o, ex_valid_o, ex_rf_a_o, ex_rf_b_o, ex_immed_o, ex_rd_o,
           ex_load_o, stall_o
  );

  modport master (
    output instr_i, instr_valid_i, use_a_i, use_b_i, rf_b_sel_i, imm_mode_i,
           sb_i, is_load_i, flush_i, wb_en_i, wb_lb_i, wb_addr_i, wb_data_i,
           ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_rf_a_o, ex_rf_b_o, ex_immed_o, ex_rd_o,
           ex_load_o, stall_o
  );
endinterface

`default_nettype wire

// File: rtl/decstage_pipe.sv
// ============================================================================
// decstage_pipe: register file, operand/immediate formation, load-use stall
// and ID/EX register. Option macro: DECSTAGE_BYPASS_EN (WB-to-read forwarding)
// Rev 1.0
// ============================================================================
`default_nettype none

module decstage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  decstage_if.slave   bus
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] rf_q [NREG];

  logic [REG_AW-1:0] w_addr_a;
  logic [REG_AW-1:0] w_addr_b;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_se;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_we;
  logic              w_stall;
  logic              w_adv;
  logic              w_unused;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_a_q,     ex_a_d;
  logic [DATA_W-1:0] ex_b_q,     ex_b_d;
  logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
  logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
  logic              ex_load_q,  ex_load_d;

  // Opcode and any register-field bits above REG_AW are not decoded here.
  assign w_unused = &{1'b0, bus.instr_i};

  assign w_addr_a = bus.instr_i[21 +: REG_AW];
  assign w_rd     = bus.instr_i[16 +: REG_AW];
  assign w_addr_b = bus.rf_b_sel_i ? w_rd : bus.instr_i[11 +: REG_AW];

  assign w_wb_we   = bus.wb_en_i && (bus.wb_addr_i != '0);
  assign w_wb_data = bus.wb_lb_i ? {{(DATA_W-8){1'b0}}, bus.wb_data_i[7:0]}
                                 : bus.wb_data_i;

  // r0 is cleared by reset and never written, so it always reads as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (w_wb_we) begin
      rf_q[bus.wb_addr_i] <= w_wb_data;
    end
  end

  always_comb begin
    w_rd_a = rf_q[w_addr_a];
    w_rd_b = rf_q[w_addr_b];
`ifdef DECSTAGE_BYPASS_EN
    if (w_wb_we && (bus.wb_addr_i == w_addr_a)) w_rd_a = w_wb_data;
    if (w_wb_we && (bus.wb_addr_i == w_addr_b)) w_rd_b = w_wb_data;
`endif
  end

  assign w_op_b = bus.sb_i ? {{(DATA_W-8){1'b0}}, w_rd_b[7:0]} : w_rd_b;

  // Upper-half and branch forms are shifts of the sign-extended value, so
  // bits above 31 follow the immediate sign for wide datapaths.
  assign w_se = {{(DATA_W-16){bus.instr_i[15]}}, bus.instr_i[15:0]};

  always_comb begin
    w_imm = w_se;
    unique case (bus.imm_mode_i)
      2'b00:   w_imm = w_se;
      2'b01:   w_imm = {{(DATA_W-16){1'b0}}, bus.instr_i[15:0]};
      2'b10:   w_imm = w_se << 16;
      default: w_imm = w_se << 2;
    endcase
  end

  assign w_stall = ex_valid_q && ex_load_q && (ex_rd_q != '0) &&
                   ((bus.use_a_i && (w_addr_a == ex_rd_q)) ||
                    (bus.use_b_i && (w_addr_b == ex_rd_q)));
  assign w_adv   = !ex_valid_q || bus.ex_ready_i;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_load_d  = ex_load_q;
    if (bus.flush_i) begin
      ex_valid_d = 1'b0;
    end else if (w_adv && w_stall) begin
      ex_valid_d = 1'b0;
    end else if (w_adv) begin
      ex_valid_d = bus.instr_valid_i;
      ex_a_d     = w_rd_a;
      ex_b_d     = w_op_b;
      ex_imm_d   = w_imm;
      ex_rd_d    = w_rd;
      ex_load_d  = bus.is_load_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      ex_load_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_load_q  <= ex_load_d;
    end
  end

  assign bus.id_ready_o = w_adv && !w_stall && !bus.flush_i;
  assign bus.stall_o    = w_stall;
  assign bus.ex_valid_o = ex_valid_q;
  assign bus.ex_rf_a_o  = ex_a_q;
  assign bus.ex_rf_b_o  = ex_b_q;
  assign bus.ex_immed_o = ex_imm_q;
  assign bus.ex_rd_o    = ex_rd_q;
  assign bus.ex_load_o  = ex_load_q;

endmodule

`default_nettype wire

// File: doc/decstage_pipe.md
# decstage_pipe

Parametrised, pipelined successor to the single-cycle decode stage. Holds the 2^REG_AW × DATA_W register file, forms the extended immediate and the byte-masked store operand, and registers everything into an ID/EX pipeline register with a valid/ready handshake. Adds load-use hazard stalling, flush, and write-back-to-read forwarding. Sits between the fetch stage (instruction in) and the execute stage (operands out).

## Interface
- DATA_W, 32, datapath width; legal values ≥ 32
- REG_AW, 5, register address width; 2^REG_AW registers, r0 reads as zero
- Clk  in  1  clock, all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Instr  in  32  fields: opcode [31:26], rs [25:21], rd [20:16], rt [15:11], immed [15:0]; register fields use their low REG_AW bits
- Instr_valid  in  1  Instr is presented
- ID_ready  out  1  Instr accepted on this edge when Instr_valid && ID_ready
- Use_A, Use_B  in  1 each  the instruction reads RF_A / RF_B (hazard qualification)
- RF_B_sel  in  1  0: the B read address is rt; 1: the B read address is rd
- Imm_mode  in  2  00 sign-ext, 01 zero-ext, 10 immed<<16 (lui), 11 sign-ext<<2 (branch)
- Sb, Is_Load  in  1 each  store-byte operand masking; the instruction is a load
- Flush  in  1  kill the ID/EX contents and the current decode
- WB_En, WB_Lb  in  1 each  write enable; zero-extend the byte write data
- WB_Addr  in  REG_AW  write address
- WB_Data  in  DATA_W  write data
- EX_ready  in  1  execute accepts the ID/EX contents
- EX_valid  out  1  ID/EX holds a valid instruction
- EX_RF_A, EX_RF_B, EX_Immed  out  DATA_W  registered operands
- EX_Rd  out  REG_AW  registered destination (Instr[20:16])
- EX_Load  out  1  registered Is_Load
- Stall  out  1  a load-use hazard is active this cycle

## Operation
- Register file: written on the edge when WB_En && WB_Addr≠0. Write data is WB_Lb ? {0, WB_Data[7:0]} : WB_Data. Writes to r0 are dropped. Reads are combinational.
- Read addresses: A = rs; B = RF_B_sel ? rd : rt.
- Store operand: B value = Sb ? {0, RF_B[7:0]} : RF_B.
- Immediate: 16-bit immed extended per Imm_mode to DATA_W.
  - Mode 10: low 16 bits are zero; bits above 31 follow bit 31 (sign-extended).
  - Mode 11: the shift is taken after sign extension.
- Hazard: Stall = EX_valid && EX_Load && EX_Rd≠0 && ((Use_A && rs==EX_Rd) || (Use_B && B addr==EX_Rd)). Stall is evaluated from the port values even when Instr_valid=0.
- Advance condition: adv = !EX_valid || EX_ready.
- ID_ready = adv && !Stall && !Flush.
- ID/EX register, evaluated per edge in priority order:
  - Flush: EX_valid←0.
  - Else if adv && Stall: insert a bubble, EX_valid←0.
  - Else if adv: load the operands and set EX_valid←Instr_valid.
  - Else: hold all outputs unchanged.
- Flush does not block the register-file write on the same edge.

## Timing
- Reset: EX_valid=0, EX_RF_A=EX_RF_B=EX_Immed=0, EX_Rd=0, EX_Load=0, and every register = 0. Reset mid-stall discards the held instruction.
- Latency: an instruction accepted at edge n appears on the EX_* outputs after edge n, i.e. 1 cycle.
- Load-use: exactly one bubble when execute is always ready. The instruction is re-accepted on the following edge.
- EX outputs are stable while EX_valid && !EX_ready, regardless of WB writes to the registers they came from.
- Simultaneous write and read of the same register (≠ r0): see Configuration.

## Configuration
- DECSTAGE_BYPASS_EN defined: a read whose address equals WB_Addr while WB_En=1 returns the write-back data, after WB_Lb masking. The value therefore enters ID/EX on the same edge as the write.
- DECSTAGE_BYPASS_EN undefined: the read returns the pre-write value. The new value is visible one cycle later, and the surrounding pipeline must cover that gap.

## Test plan
- Reset mid-hold: with EX_valid=1, EX_ready=0 and data present, assert Reset → all EX_* outputs are 0 asynchronously, and r1 reads 0.
- Write/read: WB r1=7 and r2=5. Then accept Instr=0x80231030 (add, rs=1, rt=2), RF_B_sel=0 → next cycle EX_RF_A=7, EX_RF_B=5, EX_Rd=3.
- Immediate modes with immed=0xFFFA: mode 00 → 0xFFFFFFFA; 01 → 0x0000FFFA; 10 → 0xFFFA0000; 11 → 0xFFFFFFE8.
- Byte paths:
  - Sb=1 with r3=0x0000C00F → EX_RF_B=0x0000000F.
  - WB_Lb=1, WB_Data=0xCF647855 to r4 → r4=0x00000055.
- Load-use: EX holds a load to r4 (EX_Load=1), next instruction rs=4 with Use_A=1 → Stall=1 and ID_ready=0 for one cycle. A bubble follows (EX_valid=0), then the instruction issues.
- Same-cycle bypass: WB r1=9 while decoding rs=1 → EX_RF_A=9 with DECSTAGE_BYPASS_EN defined, and the old value without it.
- Back-pressure and flush:
  - EX_ready=0 for 3 cycles → outputs held and ID_ready=0.
  - Flush=1 → EX_valid=0 next edge, and a concurrent WB write still lands.
